if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the pipelined MIPS datapath: owns the program counter, drives the instruction memory address, and holds the IF/ID pipeline register. Its registered instruction output feeds the decode stage directly; bits [15:0] of `instr_o` are the immediate field consumed by the 16→32 sign-extension unit. Supports load-use stall, bubble insertion (flush), and branch/jump redirect.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `NOP_INSTR`, 32'h0000_0000: encoding written into IF/ID when a bubble is inserted.

- `clk_i`  in  1  clock; all state updates on rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `stall_i`  in  1  hold PC and IF/ID contents (hazard unit).
- `flush_i`  in  1  replace IF/ID contents with a bubble.
- `redirect_i`  in  1  taken branch/jump resolved this cycle.
- `target_i`  in  32  redirect destination byte address.
- `imem_addr_o`  out  32  instruction memory address (= PC, combinational).
- `imem_data_i`  in  32  instruction word at `imem_addr_o` (combinational read, same cycle).
- `instr_o`  out  32  IF/ID instruction; [15:0] goes to sign extension.
- `pc_plus4_o`  out  32  IF/ID copy of fetching PC + 4.
- `valid_o`  out  1  IF/ID holds a real instruction (0 = bubble).
- `fetch_count_o`  out  32  number of instructions accepted into IF/ID.
- `addr_err_o`  out  1  sticky: a redirect target was not word-aligned.

## Operation
- State: `pc` (32), IF/ID register {`instr_o`, `pc_plus4_o`, `valid_o`}, `fetch_count_o`, `addr_err_o`.
- `imem_addr_o` = `pc` at all times; `pc` bits [1:0] are always 00.
- Per-edge priority, highest first:
  - `rst_i`: `pc` ← RESET_PC; `instr_o` ← NOP_INSTR; `pc_plus4_o` ← 0; `valid_o` ← 0; `fetch_count_o` ← 0; `addr_err_o` ← 0.
  - `redirect_i`: `pc` ← {`target_i`[31:2], 2'b00}; IF/ID ← bubble (NOP_INSTR, `pc_plus4_o` ← 0, `valid_o` ← 0). Overrides `stall_i` and `flush_i`. If `target_i`[1:0] ≠ 00, `addr_err_o` ← 1.
  - `stall_i`: `pc` holds. If `flush_i` is also high, IF/ID ← bubble; otherwise IF/ID holds.
  - `flush_i` (no stall): `pc` ← `pc` + 4; IF/ID ← bubble.
  - Normal: `pc` ← `pc` + 4; `instr_o` ← `imem_data_i`; `pc_plus4_o` ← `pc` + 4; `valid_o` ← 1; `fetch_count_o` ← `fetch_count_o` + 1.
- `fetch_count_o` increments only in the normal case and wraps modulo 2^32.
- `addr_err_o` is sticky and clears only on reset.
- PC arithmetic is 32-bit unsigned: 32'hFFFF_FFFC + 4 wraps to 0 with no flag.

## Timing
- Fetch latency is 1 cycle: the word addressed in cycle N appears on `instr_o` in cycle N+1.
- Redirect asserted in cycle N: `imem_addr_o` = target in N+1, and `valid_o` = 0 in N+1. The first target instruction appears on `instr_o` in N+2.
- Stall: outputs are frozen while `stall_i` = 1. The cycle after release, the held PC is fetched (no instruction lost or duplicated).
- Reset asserted mid-stream takes effect at the next edge regardless of other inputs. In the first cycle after deassertion, `imem_addr_o` = RESET_PC and `valid_o` = 0.

## Test plan
- Reset then free-run with imem returning addr-derived words: `imem_addr_o` = 0, 4, 8…; cycle 3 `instr_o` = word@4, `pc_plus4_o` = 8, `fetch_count_o` = 2.
- Stall 3 cycles at PC = 0x10: `imem_addr_o` stays 0x10, `instr_o` holds word@0xC. On release, next `instr_o` = word@0x10, with no duplicate count.
- Redirect to 0x100 while `stall_i` = 1: next cycle `imem_addr_o` = 0x100, `valid_o` = 0; following cycle `instr_o` = word@0x100, `pc_plus4_o` = 0x104.
- Redirect to 0x102: `pc` = 0x100, `addr_err_o` = 1 and remains 1 until `rst_i`.
- Stall+flush together at PC = 0x20: `pc` holds at 0x20, `instr_o` = NOP_INSTR, `valid_o` = 0, `fetch_count_o` unchanged. Flush alone advances PC to 0x24.
- Preload `pc` = 0xFFFF_FFFC via redirect, run 1 cycle: `imem_addr_o` = 0, `pc_plus4_o` = 0; assert `rst_i` mid-run: all outputs return to reset values in 1 edge.

Source files
------------

// File: rtl/if_stage_if.sv
// ============================================================================
// Module   : if_stage_if
// Brief    : Hazard-control, redirect and instruction-memory bundle of the fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface if_stage_if;
  logic        stall_i;
  logic        flush_i;
  logic        redirect_i;
  logic [31:0] target_i;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_data_i;
  logic [31:0] instr_o;
  logic [31:0] pc_plus4_o;
  logic        valid_o;
  logic [31:0] fetch_count_o;
  logic        addr_err_o;

  // master: hazard unit, branch resolution and instruction memory
  modport master (
    output stall_i, flush_i, redirect_i, target_i, imem_data_i,
    input  imem_addr_o, instr_o, pc_plus4_o, valid_o, fetch_count_o, addr_err_o
  );

  // slave: the fetch stage itself
  modport slave (
    input  stall_i, flush_i, redirect_i, target_i, imem_data_i,
    output imem_addr_o, instr_o, pc_plus4_o, valid_o, fetch_count_o, addr_err_o
  );
endinterface

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
// Module   : if_stage
// Brief    : MIPS instruction fetch: program counter plus IF/ID pipeline register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  wire logic clk_i,
  input  wire logic rst_i,
  if_stage_if.slave bus
);

  localparam logic [31:0] c_PC_STEP = 32'd4;

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pc_plus4;
  logic        r_valid;
  logic [31:0] r_fetch_count;
  logic        r_addr_err;

  logic [31:0] w_pc_inc;
  logic [31:0] w_target_aligned;
  logic        w_target_misaligned;

  always_comb begin
    w_pc_inc            = r_pc + c_PC_STEP;
    w_target_aligned    = {bus.target_i[31:2], 2'b00};
    w_target_misaligned = (bus.target_i[1:0] != 2'b00);
  end

  // Redirect beats stall beats flush; the PC never leaves word alignment.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pc          <= {RESET_PC[31:2], 2'b00};
      r_instr       <= NOP_INSTR;
      r_pc_plus4    <= 32'd0;
      r_valid       <= 1'b0;
      r_fetch_count <= 32'd0;
      r_addr_err    <= 1'b0;
    end else if (bus.redirect_i) begin
      r_pc       <= w_target_aligned;
      r_instr    <= NOP_INSTR;
      r_pc_plus4 <= 32'd0;
      r_valid    <= 1'b0;
      if (w_target_misaligned) begin
        r_addr_err <= 1'b1;
      end
    end else if (bus.stall_i) begin
      if (bus.flush_i) begin
        r_instr    <= NOP_INSTR;
        r_pc_plus4 <= 32'd0;
        r_valid    <= 1'b0;
      end
    end else if (bus.flush_i) begin
      r_pc       <= w_pc_inc;
      r_instr    <= NOP_INSTR;
      r_pc_plus4 <= 32'd0;
      r_valid    <= 1'b0;
    end else begin
      r_pc          <= w_pc_inc;
      r_instr       <= bus.imem_data_i;
      r_pc_plus4    <= w_pc_inc;
      r_valid       <= 1'b1;
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign bus.imem_addr_o   = r_pc;
  assign bus.instr_o       = r_instr;
  assign bus.pc_plus4_o    = r_pc_plus4;
  assign bus.valid_o       = r_valid;
  assign bus.fetch_count_o = r_fetch_count;
  assign bus.addr_err_o    = r_addr_err;

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
// Module   : tb_if_stage
// Brief    : Directed self-checking bench for the fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_stage;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  if_stage_if bus ();

  if_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0000)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Instruction memory: each word is its own address XOR a tag.
  assign bus.imem_data_i = bus.imem_addr_o ^ 32'hC0DE_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.stall_i = 1'b0; bus.flush_i = 1'b0; bus.redirect_i = 1'b0; bus.target_i = 32'd0;
    step(); step();
    rst = 1'b0;
    checks++; if (bus.imem_addr_o !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=%h", bus.imem_addr_o, 32'h0); end
    checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.valid_o); end
    checks++; if (bus.instr_o !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", bus.instr_o); end
    checks++; if (bus.pc_plus4_o !== 32'h0) begin failures++; $display("FAIL reset_pp4 got=%h exp=0", bus.pc_plus4_o); end
    checks++; if (bus.fetch_count_o !== 32'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.fetch_count_o); end
    checks++; if (bus.addr_err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus.addr_err_o); end
  endtask

  task automatic test_free_run();
    step();
    checks++; if (bus.instr_o !== 32'hC0DE_0000) begin failures++; $display("FAIL run1_instr got=%h exp=%h", bus.instr_o, 32'hC0DE_0000); end
    checks++; if (bus.imem_addr_o !== 32'h4) begin failures++; $display("FAIL run1_addr got=%h exp=4", bus.imem_addr_o); end
    step();
    checks++; if (bus.instr_o !== 32'hC0DE_0004) begin failures++; $display("FAIL run2_instr got=%h exp=%h", bus.instr_o, 32'hC0DE_0004); end
    checks++; if (bus.pc_plus4_o !== 32'h8) begin failures++; $display("FAIL run2_pp4 got=%h exp=8", bus.pc_plus4_o); end
    checks++; if (bus.fetch_count_o !== 32'd2) begin failures++; $display("FAIL run2_count got=%0d exp=2", bus.fetch_count_o); end
    checks++; if (bus.valid_o !== 1'b1) begin failures++; $display("FAIL run2_valid got=%b exp=1", bus.valid_o); end
    step(); step();
    checks++; if (bus.imem_addr_o !== 32'h10) begin failures++; $display("FAIL run4_addr got=%h exp=10", bus.imem_addr_o); end
  endtask

  task automatic test_stall();
    bus.stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.imem_addr_o !== 32'h10) begin failures++; $display("FAIL stall_addr[%0d] got=%h exp=10", i, bus.imem_addr_o); end
      checks++; if (bus.instr_o !== 32'hC0DE_000C) begin failures++; $display("FAIL stall_instr[%0d] got=%h exp=%h", i, bus.instr_o, 32'hC0DE_000C); end
      checks++; if (bus.fetch_count_o !== 32'd4) begin failures++; $display("FAIL stall_count[%0d] got=%0d exp=4", i, bus.fetch_count_o); end
    end
    bus.stall_i = 1'b0;
    step();
    checks++; if (bus.instr_o !== 32'hC0DE_0010) begin failures++; $display("FAIL unstall_instr got=%h exp=%h", bus.instr_o, 32'hC0DE_0010); end
    checks++; if (bus.fetch_count_o !== 32'd5) begin failures++; $display("FAIL unstall_count got=%0d exp=5", bus.fetch_count_o); end
    checks++; if (bus.imem_addr_o !== 32'h14) begin failures++; $display("FAIL unstall_addr got=%h exp=14", bus.imem_addr_o); end
  endtask

  task automatic test_redirect_stall();
    bus.stall_i = 1'b1; bus.redirect_i = 1'b1; bus.target_i = 32'h100;
    step();
    bus.stall_i = 1'b0; bus.redirect_i = 1'b0;
    checks++; if (bus.imem_addr_o !== 32'h100) begin failures++; $display("FAIL redir_addr got=%h exp=100", bus.imem_addr_o); end
    checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL redir_valid got=%b exp=0", bus.valid_o); end
    checks++; if (bus.instr_o !== 32'h0) begin failures++; $display("FAIL redir_instr got=%h exp=0", bus.instr_o); end
    checks++; if (bus.fetch_count_o !== 32'd5) begin failures++; $display("FAIL redir_count got=%0d exp=5", bus.fetch_count_o); end
    step();
    checks++; if (bus.instr_o !== 32'hC0DE_0100) begin failures++; $display("FAIL redir_tgt_instr got=%h exp=%h", bus.instr_o, 32'hC0DE_0100); end
    checks++; if (bus.pc_plus4_o !== 32'h104) begin failures++; $display("FAIL redir_tgt_pp4 got=%h exp=104", bus.pc_plus4_o); end
    checks++; if (bus.addr_err_o !== 1'b0) begin failures++; $display("FAIL redir_err got=%b exp=0", bus.addr_err_o); end
  endtask

  task automatic test_misaligned();
    bus.redirect_i = 1'b1; bus.target_i = 32'h102;
    step();
    bus.redirect_i = 1'b0;
    checks++; if (bus.imem_addr_o !== 32'h100) begin failures++; $display("FAIL mis_addr got=%h exp=100", bus.imem_addr_o); end
    checks++; if (bus.addr_err_o !== 1'b1) begin failures++; $display("FAIL mis_err got=%b exp=1", bus.addr_err_o); end
    step(); step();
    checks++; if (bus.addr_err_o !== 1'b1) begin failures++; $display("FAIL mis_err_sticky got=%b exp=1", bus.addr_err_o); end
    checks++; if (bus.fetch_count_o !== 32'd8) begin failures++; $display("FAIL mis_count got=%0d exp=8", bus.fetch_count_o); end
    checks++; if (bus.imem_addr_o !== 32'h108) begin failures++; $display("FAIL mis_addr2 got=%h exp=108", bus.imem_addr_o); end
  endtask

  task automatic test_stall_flush();
    bus.redirect_i = 1'b1; bus.target_i = 32'h20;
    step();
    bus.redirect_i = 1'b0; bus.stall_i = 1'b1; bus.flush_i = 1'b1;
    step();
    checks++; if (bus.imem_addr_o !== 32'h20) begin failures++; $display("FAIL sf_addr got=%h exp=20", bus.imem_addr_o); end
    checks++; if (bus.instr_o !== 32'h0) begin failures++; $display("FAIL sf_instr got=%h exp=0", bus.instr_o); end
    checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL sf_valid got=%b exp=0", bus.valid_o); end
    checks++; if (bus.fetch_count_o !== 32'd8) begin failures++; $display("FAIL sf_count got=%0d exp=8", bus.fetch_count_o); end
    bus.stall_i = 1'b0;
    step();
    bus.flush_i = 1'b0;
    checks++; if (bus.imem_addr_o !== 32'h24) begin failures++; $display("FAIL flush_addr got=%h exp=24", bus.imem_addr_o); end
    checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", bus.valid_o); end
    checks++; if (bus.fetch_count_o !== 32'd8) begin failures++; $display("FAIL flush_count got=%0d exp=8", bus.fetch_count_o); end
    step();
    checks++; if (bus.instr_o !== 32'hC0DE_0024) begin failures++; $display("FAIL postflush_instr got=%h exp=%h", bus.instr_o, 32'hC0DE_0024); end
    checks++; if (bus.pc_plus4_o !== 32'h28) begin failures++; $display("FAIL postflush_pp4 got=%h exp=28", bus.pc_plus4_o); end
    checks++; if (bus.fetch_count_o !== 32'd9) begin failures++; $display("FAIL postflush_count got=%0d exp=9", bus.fetch_count_o); end
  endtask

  task automatic test_wrap_and_reset();
    bus.redirect_i = 1'b1; bus.target_i = 32'hFFFF_FFFC;
    step();
    bus.redirect_i = 1'b0;
    checks++; if (bus.imem_addr_o !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_pre_addr got=%h exp=fffffffc", bus.imem_addr_o); end
    step();
    checks++; if (bus.imem_addr_o !== 32'h0) begin failures++; $display("FAIL wrap_addr got=%h exp=0", bus.imem_addr_o); end
    checks++; if (bus.pc_plus4_o !== 32'h0) begin failures++; $display("FAIL wrap_pp4 got=%h exp=0", bus.pc_plus4_o); end
    checks++; if (bus.instr_o !== 32'h3F21_FFFC) begin failures++; $display("FAIL wrap_instr got=%h exp=3f21fffc", bus.instr_o); end
    checks++; if (bus.valid_o !== 1'b1) begin failures++; $display("FAIL wrap_valid got=%b exp=1", bus.valid_o); end
    checks++; if (bus.fetch_count_o !== 32'd10) begin failures++; $display("FAIL wrap_count got=%0d exp=10", bus.fetch_count_o); end
    step();
    rst = 1'b1; bus.redirect_i = 1'b1; bus.target_i = 32'h41; bus.stall_i = 1'b1;
    step();
    rst = 1'b0; bus.redirect_i = 1'b0; bus.stall_i = 1'b0;
    checks++; if (bus.imem_addr_o !== 32'h0) begin failures++; $display("FAIL midrst_addr got=%h exp=0", bus.imem_addr_o); end
    checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", bus.valid_o); end
    checks++; if (bus.instr_o !== 32'h0) begin failures++; $display("FAIL midrst_instr got=%h exp=0", bus.instr_o); end
    checks++; if (bus.pc_plus4_o !== 32'h0) begin failures++; $display("FAIL midrst_pp4 got=%h exp=0", bus.pc_plus4_o); end
    checks++; if (bus.fetch_count_o !== 32'd0) begin failures++; $display("FAIL midrst_count got=%0d exp=0", bus.fetch_count_o); end
    checks++; if (bus.addr_err_o !== 1'b0) begin failures++; $display("FAIL midrst_err got=%b exp=0", bus.addr_err_o); end
    step();
    checks++; if (bus.instr_o !== 32'hC0DE_0000) begin failures++; $display("FAIL postrst_instr got=%h exp=%h", bus.instr_o, 32'hC0DE_0000); end
    checks++; if (bus.fetch_count_o !== 32'd1) begin failures++; $display("FAIL postrst_count got=%0d exp=1", bus.fetch_count_o); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_free_run();
    test_stall();
    test_redirect_stall();
    test_misaligned();
    test_stall_flush();
    test_wrap_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
